// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder that forms a + b + cin LSB first, one bit per
//            clock, using a single full-adder cell.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_s;
    logic             w_c_next;
    logic [WIDTH-1:0] w_sum_next;

    // The single full-adder cell shared by every bit position.
    assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_next   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
    assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_c      <= w_c_next;
                    r_cnt    <= r_cnt + 1'b1;
                    // The last bit is folded into the published result on the same edge.
                    if (r_cnt == C_LAST_CNT) begin
                        r_sum   <= w_sum_next;
                        r_carry <= w_c_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder (WIDTH = 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e_v);
        checks = checks + 1;
        if (obs !== e_v) begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present operands and pulse start for exactly the accepting edge.
    task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_done", done, 1'b0);
    endtask

    // Called right after the accepting edge; done must appear after WIDTH more edges.
    task automatic wait_done(input string tag, input logic [WIDTH-1:0] exp_sum, input logic exp_carry);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n = n + 1;
        end
        check({tag, "_latency"}, n, WIDTH);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_carry"}, carry, exp_carry);
        tick();
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int ndone;
        logic [WIDTH-1:0] exp_v;

        // Reset with start held high: start must be ignored while rst_n=0.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_carry", carry, 1'b0);
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        check("first_accept", busy, 1'b1);
        check("hold_during_busy", sum, 8'h00);
        wait_done("post_rst", 8'h03, 1'b0);

        accept(8'h5A, 8'h3C, 1'b0);
        wait_done("5a_3c", 8'h96, 1'b0);
        accept(8'hFF, 8'h01, 1'b0);
        check("sum_held_busy", sum, 8'h96);
        wait_done("ff_01", 8'h00, 1'b1);
        accept(8'hFF, 8'hFF, 1'b1);
        wait_done("all_ones", 8'hFF, 1'b1);
        accept(8'h00, 8'h00, 1'b1);
        wait_done("cin_only", 8'h01, 1'b0);
        accept(8'h00, 8'h00, 1'b0);
        wait_done("zeros", 8'h00, 1'b0);

        // Start during SHIFT is dropped; operand churn must not disturb the result.
        accept(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        a = 8'hAA;
        b = 8'h55;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            start = (i == 0);
            tick();
            a = a + 8'h13;
            b = b ^ 8'h5A;
            if (done === 1'b1) begin
                ndone = ndone + 1;
                check("busy_sum", sum, 8'h30);
                check("busy_carry", carry, 1'b0);
            end
        end
        start = 1'b0;
        check("busy_one_done", ndone, 1);
        check("busy_no_queue", busy, 1'b0);

        // Reset on the fourth SHIFT edge aborts the operation.
        accept(8'hF0, 8'h0F, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_carry", carry, 1'b0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone = ndone + 1;
        end
        check("abort_no_done", ndone, 0);
        accept(8'h01, 8'h01, 1'b0);
        wait_done("after_abort", 8'h02, 1'b0);

        // Full-adder truth table through the low slice.
        for (int k = 0; k < 8; k++) begin
            accept({7'b0, k[0]}, {7'b0, k[1]}, k[2]);
            wait_done("fa_slice", {6'b0, k[0] & k[1] | k[0] & k[2] | k[1] & k[2], k[0] ^ k[1] ^ k[2]}, 1'b0);
            exp_v = {6'b0, (k[0] & k[1]) | (k[0] & k[2]) | (k[1] & k[2]), k[0] ^ k[1] ^ k[2]};
            check("fa_s0", sum[0], exp_v[0]);
            check("fa_s1", sum[1], exp_v[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
